// File: rtl/cp0_int_ctrl_pkg.sv
// Shared definitions for the CP0 interrupt controller: register indices,
// status/cause field positions and word-packing helpers.
package cp0_int_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    localparam logic [4:0] EXCCODE_INT = 5'd0;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    function automatic logic [31:0] pack_sr(input sr_t sr);
        logic [31:0] word;
        word                = 32'd0;
        word[IM_HI:IM_LO]   = sr.im;
        word[EXL_BIT]       = sr.exl;
        word[IE_BIT]        = sr.ie;
        return word;
    endfunction

    function automatic logic [31:0] pack_cause(input logic [5:0] ip);
        logic [31:0] word;
        word                = 32'd0;
        word[IM_HI:IM_LO]   = ip;
        word[6:2]           = EXCCODE_INT;
        return word;
    endfunction

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// Pipeline-to-CP0 interface: mfc0/mtc0 access, interrupt lines and
// exception entry/return handshake.
interface cp0_int_ctrl_if;

    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic [5:0]  HWInt;
    logic        EXLSet;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    modport master (
        output A1, A2, DIn, We, PC, HWInt, EXLSet, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A1, A2, DIn, We, PC, HWInt, EXLSet, EXLClr,
        output IntReq, EPC, DOut
    );

endinterface

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 interrupt controller: SR/Cause/EPC/PRId register file,
// interrupt request generation and EPC capture on exception entry.
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4D50,
    parameter logic [31:0] EPC_RESET  = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          reset,
    cp0_int_ctrl_if.slave bus
);

    sr_t         sr_r;
    sr_t         sr_nxt_s;
    logic [5:0]  ip_r;
    logic [31:0] epc_r;
    logic [31:0] epc_nxt_s;
    logic        sr_we_s;
    logic        epc_we_s;
    logic        unused_pc_s;

    // Next-state selection; exception entry outranks eret, which outranks mtc0.
    always_comb begin
        sr_we_s  = bus.We && (bus.A2 == CP0_SR);
        epc_we_s = bus.We && (bus.A2 == CP0_EPC);
        sr_nxt_s = sr_r;
        if (sr_we_s) begin
            sr_nxt_s.im  = bus.DIn[IM_HI:IM_LO];
            sr_nxt_s.exl = bus.DIn[EXL_BIT];
            sr_nxt_s.ie  = bus.DIn[IE_BIT];
        end else begin
            sr_nxt_s = sr_r;
        end
        if (bus.EXLSet) begin
            sr_nxt_s.exl = 1'b1;
        end else if (bus.EXLClr) begin
            sr_nxt_s.exl = 1'b0;
        end else begin
            sr_nxt_s.exl = sr_nxt_s.exl;
        end
        if (bus.EXLSet) begin
            epc_nxt_s = {bus.PC[31:2], 2'b00};
        end else if (epc_we_s) begin
            epc_nxt_s = {bus.DIn[31:2], 2'b00};
        end else begin
            epc_nxt_s = epc_r;
        end
    end

    // State registers; IP samples the level-sensitive device lines every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_r  <= sr_t'(8'd0);
            ip_r  <= 6'd0;
            epc_r <= EPC_RESET;
        end else begin
            sr_r  <= sr_nxt_s;
            ip_r  <= bus.HWInt;
            epc_r <= epc_nxt_s;
        end
    end

    // mfc0 read mux; indices compare on all five bits so no aliasing occurs.
    always_comb begin
        case (bus.A1)
            CP0_SR:    bus.DOut = pack_sr(sr_r);
            CP0_CAUSE: bus.DOut = pack_cause(ip_r);
            CP0_EPC:   bus.DOut = epc_r;
            CP0_PRID:  bus.DOut = PRID_VALUE;
            default:   bus.DOut = 32'd0;
        endcase
    end

    assign bus.IntReq  = (|(ip_r & sr_r.im)) & sr_r.ie & ~sr_r.exl;
    assign bus.EPC     = epc_r;
    assign unused_pc_s = ^bus.PC[1:0];

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Self-checking bench for cp0_int_ctrl: directed scenarios followed by
// randomized traffic against a word-level reference model.
module tb_cp0_int_ctrl;

    localparam logic [31:0] PRID    = 32'h0000_4D50;
    localparam logic [31:0] EPC_RST = 32'h0000_3000;

    logic clk;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    logic [31:0] m_sr;
    logic [31:0] m_epc;
    logic [5:0]  m_ip;

    cp0_int_ctrl_if bus ();

    cp0_int_ctrl #(.PRID_VALUE(PRID), .EPC_RESET(EPC_RST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench did not finish");
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task idle_inputs;
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.We = 1'b0;
        bus.PC = 32'd0; bus.HWInt = 6'd0; bus.EXLSet = 1'b0; bus.EXLClr = 1'b0;
    endtask

    task model_reset;
        m_sr  = 32'd0;
        m_ip  = 6'd0;
        m_epc = EPC_RST;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        case (idx)
            5'd12:   return m_sr;
            5'd13:   return {16'd0, m_ip, 10'd0};
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_intreq();
        return ((m_ip & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    // Apply the rules in increasing priority so the last assignment wins.
    task model_edge;
        logic [31:0] sr_n;
        logic [31:0] epc_n;
        sr_n  = m_sr;
        epc_n = m_epc;
        if (bus.We && bus.A2 == 5'd12) sr_n = bus.DIn & 32'h0000_FC03;
        if (bus.EXLClr) sr_n = sr_n & ~32'h0000_0002;
        if (bus.EXLSet) sr_n = sr_n | 32'h0000_0002;
        if (bus.We && bus.A2 == 5'd14) epc_n = bus.DIn & ~32'h0000_0003;
        if (bus.EXLSet) epc_n = bus.PC & ~32'h0000_0003;
        m_sr  = sr_n;
        m_epc = epc_n;
        m_ip  = bus.HWInt;
    endtask

    function automatic logic [4:0] pick_idx();
        case ($urandom_range(0, 5))
            0:       return 5'd12;
            1:       return 5'd13;
            2:       return 5'd14;
            3:       return 5'd15;
            4:       return 5'd28;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task test_reset;
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        total++; if (bus.IntReq !== 1'b0) $display("FAIL reset_intreq: got %b want %b", bus.IntReq, 1'b0); else passed++;
        bus.A1 = 5'd12; #1;
        total++; if (bus.DOut !== 32'd0) $display("FAIL reset_sr: got %h want %h", bus.DOut, 32'd0); else passed++;
        bus.A1 = 5'd13; #1;
        total++; if (bus.DOut !== 32'd0) $display("FAIL reset_cause: got %h want %h", bus.DOut, 32'd0); else passed++;
        bus.A1 = 5'd14; #1;
        total++; if (bus.DOut !== EPC_RST) $display("FAIL reset_epc: got %h want %h", bus.DOut, EPC_RST); else passed++;
        bus.A1 = 5'd15; #1;
        total++; if (bus.DOut !== PRID) $display("FAIL reset_prid: got %h want %h", bus.DOut, PRID); else passed++;
        bus.A1 = 5'd28; #1;
        total++; if (bus.DOut !== 32'd0) $display("FAIL reset_alias: got %h want %h", bus.DOut, 32'd0); else passed++;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task test_enable_raise;
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        tick();
        bus.We = 1'b0; bus.A1 = 5'd12; #1;
        total++; if (bus.DOut !== 32'h0000_0401) $display("FAIL enable_sr: got %h want %h", bus.DOut, 32'h0000_0401); else passed++;
        bus.HWInt = 6'b000001; #1;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL raise_lag: got %b want %b", bus.IntReq, 1'b0); else passed++;
        tick();
        bus.A1 = 5'd13; #1;
        total++; if (bus.DOut !== 32'h0000_0400) $display("FAIL raise_cause: got %h want %h", bus.DOut, 32'h0000_0400); else passed++;
        total++; if (bus.IntReq !== 1'b1) $display("FAIL raise_intreq: got %b want %b", bus.IntReq, 1'b1); else passed++;
    endtask

    task test_entry;
        bus.EXLSet = 1'b1; bus.PC = 32'h0000_3010;
        tick();
        bus.EXLSet = 1'b0; bus.A1 = 5'd12; #1;
        total++; if (bus.EPC !== 32'h0000_3010) $display("FAIL entry_epc: got %h want %h", bus.EPC, 32'h0000_3010); else passed++;
        total++; if (bus.DOut !== 32'h0000_0403) $display("FAIL entry_sr: got %h want %h", bus.DOut, 32'h0000_0403); else passed++;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL entry_intreq: got %b want %b", bus.IntReq, 1'b0); else passed++;
    endtask

    task test_masking;
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0801;
        tick();
        bus.We = 1'b0; bus.A1 = 5'd12; #1;
        total++; if (bus.DOut !== 32'h0000_0801) $display("FAIL mask_sr: got %h want %h", bus.DOut, 32'h0000_0801); else passed++;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL mask_blocked: got %b want %b", bus.IntReq, 1'b0); else passed++;
        bus.HWInt = 6'b000011; #1;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL mask_lag: got %b want %b", bus.IntReq, 1'b0); else passed++;
        tick();
        bus.A1 = 5'd13; #1;
        total++; if (bus.IntReq !== 1'b1) $display("FAIL mask_enabled: got %b want %b", bus.IntReq, 1'b1); else passed++;
        total++; if (bus.DOut !== 32'h0000_0C00) $display("FAIL mask_cause: got %h want %h", bus.DOut, 32'h0000_0C00); else passed++;
    endtask

    task test_collision;
        bus.EXLSet = 1'b1; bus.We = 1'b1; bus.A2 = 5'd14;
        bus.DIn = 32'h0000_5555; bus.PC = 32'h0000_3020;
        tick();
        bus.EXLSet = 1'b0; bus.We = 1'b0; bus.A1 = 5'd12; #1;
        total++; if (bus.EPC !== 32'h0000_3020) $display("FAIL coll_epc: got %h want %h", bus.EPC, 32'h0000_3020); else passed++;
        total++; if (bus.DOut !== 32'h0000_0803) $display("FAIL coll_sr: got %h want %h", bus.DOut, 32'h0000_0803); else passed++;
        bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3007; bus.A1 = 5'd14; #1;
        total++; if (bus.DOut !== 32'h0000_3020) $display("FAIL no_bypass: got %h want %h", bus.DOut, 32'h0000_3020); else passed++;
        tick();
        bus.We = 1'b0; #1;
        total++; if (bus.DOut !== 32'h0000_3004) $display("FAIL epc_align: got %h want %h", bus.DOut, 32'h0000_3004); else passed++;
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        bus.EXLSet = 1'b1; bus.PC = 32'h0000_3040;
        tick();
        bus.We = 1'b0; bus.EXLSet = 1'b0; bus.A1 = 5'd12; #1;
        total++; if (bus.DOut !== 32'h0000_0403) $display("FAIL coll_sr_exl: got %h want %h", bus.DOut, 32'h0000_0403); else passed++;
        total++; if (bus.EPC !== 32'h0000_3040) $display("FAIL coll_sr_epc: got %h want %h", bus.EPC, 32'h0000_3040); else passed++;
    endtask

    task test_return;
        bus.HWInt = 6'b000001; bus.EXLClr = 1'b1; #1;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL ret_before: got %b want %b", bus.IntReq, 1'b0); else passed++;
        tick();
        bus.EXLClr = 1'b0; bus.A1 = 5'd12; #1;
        total++; if (bus.DOut !== 32'h0000_0401) $display("FAIL ret_sr: got %h want %h", bus.DOut, 32'h0000_0401); else passed++;
        total++; if (bus.IntReq !== 1'b1) $display("FAIL ret_reassert: got %b want %b", bus.IntReq, 1'b1); else passed++;
        bus.EXLSet = 1'b1; bus.EXLClr = 1'b1; bus.PC = 32'h0000_3050;
        tick();
        bus.EXLSet = 1'b0; bus.EXLClr = 1'b0; #1;
        total++; if (bus.DOut !== 32'h0000_0403) $display("FAIL set_over_clr: got %h want %h", bus.DOut, 32'h0000_0403); else passed++;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL set_over_clr_irq: got %b want %b", bus.IntReq, 1'b0); else passed++;
    endtask

    task test_async_reset;
        bus.A1 = 5'd12;
        #3;
        reset = 1'b1;
        #1;
        total++; if (bus.DOut !== 32'd0) $display("FAIL areset_sr: got %h want %h", bus.DOut, 32'd0); else passed++;
        total++; if (bus.EPC !== EPC_RST) $display("FAIL areset_epc: got %h want %h", bus.EPC, EPC_RST); else passed++;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL areset_intreq: got %b want %b", bus.IntReq, 1'b0); else passed++;
        bus.A1 = 5'd15; #1;
        total++; if (bus.DOut !== PRID) $display("FAIL areset_prid: got %h want %h", bus.DOut, PRID); else passed++;
        reset = 1'b0;
        tick();
        bus.A1 = 5'd13; #1;
        total++; if (bus.DOut !== 32'h0000_0400) $display("FAIL areset_cause: got %h want %h", bus.DOut, 32'h0000_0400); else passed++;
        total++; if (bus.IntReq !== 1'b0) $display("FAIL areset_dropped: got %b want %b", bus.IntReq, 1'b0); else passed++;
    endtask

    task test_random;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            bus.We     = ($urandom_range(0, 2) == 0);
            bus.A2     = pick_idx();
            bus.A1     = pick_idx();
            bus.DIn    = $urandom;
            bus.PC     = $urandom;
            bus.EXLSet = ($urandom_range(0, 5) == 0);
            bus.EXLClr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) bus.HWInt = 6'($urandom_range(0, 63));
            #1;
            total++; if (bus.DOut !== m_read(bus.A1)) $display("FAIL rand_dout[%0d] a1=%0d: got %h want %h", i, bus.A1, bus.DOut, m_read(bus.A1)); else passed++;
            total++; if (bus.IntReq !== m_intreq()) $display("FAIL rand_intreq[%0d]: got %b want %b", i, bus.IntReq, m_intreq()); else passed++;
            total++; if (bus.EPC !== m_epc) $display("FAIL rand_epc[%0d]: got %h want %h", i, bus.EPC, m_epc); else passed++;
            model_edge();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_enable_raise();
        test_entry();
        test_masking();
        test_collision();
        test_return();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
